// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : regfile_pkg
//  Purpose : Shared types and constants for the 2-read/1-write register file:
//            sweep FSM state encoding, default geometry and a helper that
//            derives the entry count from the address width.
//  Ports   : none (package)
//  Options : REGFILE_BYPASS_EN (used by regfile_rdport / regfile_2r1w)
//  Rev     : 1.0  initial release
// ============================================================================
package regfile_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  function automatic int num_regs(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_rdport.sv
`default_nettype none
// ============================================================================
//  Module  : regfile_rdport
//  Purpose : One registered read port of the register file. Selects the
//            addressed entry and captures it when re is high; rvalid pulses
//            for the cycle after each accepted read.
//  Ports   : clk, reset      - clock, async active-high reset
//            re, raddr       - read enable / address
//            mem             - current storage contents
//            wr_en, waddr,
//            wdata           - accepted write of this cycle (forwarding only)
//            rdata, rvalid   - registered read data and update pulse
//  Options : REGFILE_BYPASS_EN - forward an accepted same-address write
//  Rev     : 1.0  initial release
// ============================================================================
module regfile_rdport import regfile_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] mem [num_regs(ADDR_W)],
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  logic [DATA_W-1:0] sel;

`ifdef REGFILE_BYPASS_EN
  // wr_en is only high for writes that will really land, so dropped writes
  // and sweep zeros are never forwarded.
  always_comb begin
    sel = mem[raddr];
    if (wr_en && (waddr == raddr)) sel = wdata;
  end
`else
  always_comb begin
    sel = mem[raddr];
  end

  logic unused_bypass;
  assign unused_bypass = ^{wr_en, waddr, wdata};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) rdata <= sel;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
//  Module  : regfile_2r1w
//  Purpose : Parametrised register file with one write port, two independent
//            registered read ports and a clear-sweep sequencer that zeroes
//            one entry per cycle after a clr request.
//  Ports   : clk, reset                  - clock, async active-high reset
//            we, waddr, wdata            - write port
//            re_a, raddr_a, rdata_a,
//            rvalid_a                    - read port A
//            re_b, raddr_b, rdata_b,
//            rvalid_b                    - read port B
//            clr                         - sweep request (taken when idle)
//            busy                        - sweep in progress
//            wr_drop                     - pulse: write discarded by sweep
//  Options : REGFILE_BYPASS_EN - write-through forwarding on both read ports
//  Rev     : 1.0  initial release
// ============================================================================
module regfile_2r1w import regfile_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  output logic              rvalid_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid_b,
  input  logic              clr,
  output logic              busy,
  output logic              wr_drop
);

  localparam int NUM_REGS = num_regs(ADDR_W);

  logic [DATA_W-1:0] mem [NUM_REGS];
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              wr_ok;

  assign wr_ok = we && (state == ST_IDLE);
  assign busy  = (state == ST_SWEEP);

  // ---------------- sweep FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // The last entry is cleared in the cycle ptr is all-ones, giving exactly
  // NUM_REGS busy cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (clr)  state_nxt = ST_SWEEP;
      ST_SWEEP: if (&ptr) state_nxt = ST_IDLE;
      default:            state_nxt = ST_IDLE;
    endcase
  end

  // Held at zero while idle; after the final entry it wraps back to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  ptr <= '0;
    else if (state == ST_SWEEP) ptr <= ptr + 1'b1;
    else                        ptr <= '0;
  end

  // ---------------- storage ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (state == ST_SWEEP) begin
      mem[ptr] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_drop <= 1'b0;
    else       wr_drop <= we && (state == ST_SWEEP);
  end

  // ---------------- read ports ----------------
  regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_a (
    .clk    (clk),
    .reset  (reset),
    .re     (re_a),
    .raddr  (raddr_a),
    .mem    (mem),
    .wr_en  (wr_ok),
    .waddr  (waddr),
    .wdata  (wdata),
    .rdata  (rdata_a),
    .rvalid (rvalid_a)
  );

  regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_b (
    .clk    (clk),
    .reset  (reset),
    .re     (re_b),
    .raddr  (raddr_b),
    .mem    (mem),
    .wr_en  (wr_ok),
    .waddr  (waddr),
    .wdata  (wdata),
    .rdata  (rdata_b),
    .rvalid (rvalid_b)
  );

endmodule
`default_nettype wire
